// File: rtl/mmul_pkg.sv
// Shared types and sizes for the matrix-multiply job scheduler.
// Latency: n/a; backpressure: n/a.
package mmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LOAD,
        WAIT,
        READ,
        DONE
    } sched_state_t;

    typedef enum logic {
        OP_COMPUTE = 1'b0,
        OP_READ    = 1'b1
    } op_t;

    localparam int SLOT_W      = 5;
    localparam int LOAD_WORDS  = 32;
    localparam int READ_CYCLES = 32;
    localparam int CNT_W       = 9;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past ptr and wraps.
// Latency: 0 cycles; backpressure: none, the caller owns the pointer register.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mmul_job_sched.sv
// Shares one matrix-multiply accelerator between N_REQ requesters, one job at a time.
// Latency: grant one cycle after req; backpressure: req is held until gnt, other requesters wait.
module mmul_job_sched
    import mmul_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_op,
    input  logic [SLOT_W*N_REQ-1:0]  req_slot,
    input  logic [DATA_W*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         load_en,
    output logic [N_REQ-1:0]         rd_valid,
    output logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         err,
    output logic                     busy,
    output logic                     acc_start,
    output logic                     acc_read,
    output logic [SLOT_W-1:0]        acc_in_addr,
    output logic [DATA_W-1:0]        acc_data,
    input  logic                     acc_finish
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_WORDS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] RD_FIRST  = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LAT + READ_CYCLES - 1);

    sched_state_t      state, state_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [N_REQ-1:0]  owner_oh, owner_oh_nxt;
    op_t               op, op_nxt;
    logic [SLOT_W-1:0] slot, slot_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic              timed_out, timed_out_nxt;

    logic [N_REQ-1:0]  win_oh;
    logic [IDX_W-1:0]  win_idx;
    logic [SLOT_W-1:0] slot_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign slot_arr[g] = req_slot[g*SLOT_W +: SLOT_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (win_oh),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            owner_oh  <= '0;
            op        <= OP_COMPUTE;
            slot      <= '0;
            cnt       <= '0;
            ptr       <= IDX_W'(N_REQ - 1);
            timed_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            owner_oh  <= owner_oh_nxt;
            op        <= op_nxt;
            slot      <= slot_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        owner_oh_nxt  = owner_oh;
        op_nxt        = op;
        slot_nxt      = slot;
        cnt_nxt       = cnt;
        ptr_nxt       = ptr;
        timed_out_nxt = timed_out;

        gnt         = '0;
        load_en     = '0;
        rd_valid    = '0;
        done        = '0;
        err         = '0;
        busy        = 1'b1;
        acc_start   = 1'b0;
        acc_read    = 1'b0;
        acc_in_addr = '0;
        acc_data    = '0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    owner_nxt     = win_idx;
                    owner_oh_nxt  = win_oh;
                    op_nxt        = op_t'(req_op[win_idx]);
                    slot_nxt      = slot_arr[win_idx];
                    ptr_nxt       = win_idx;
                    cnt_nxt       = '0;
                    timed_out_nxt = 1'b0;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                gnt         = owner_oh;
                acc_in_addr = slot;
                // The accelerator captures word 0 together with the start pulse.
                if (op == OP_COMPUTE) begin
                    acc_start = 1'b1;
                    load_en   = owner_oh;
                    acc_data  = data_arr[owner];
                    cnt_nxt   = CNT_ONE;
                    state_nxt = LOAD;
                end else begin
                    acc_read  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = READ;
                end
            end
            LOAD: begin
                load_en  = owner_oh;
                acc_data = data_arr[owner];
                if (cnt == LOAD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            WAIT: begin
                // A finish arriving in the last timeout cycle still wins.
                if (acc_finish) begin
                    cnt_nxt       = '0;
                    timed_out_nxt = 1'b0;
                    state_nxt     = DONE;
                end else if (cnt == TMO_LAST) begin
                    cnt_nxt       = '0;
                    timed_out_nxt = 1'b1;
                    state_nxt     = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            READ: begin
                if (cnt >= RD_FIRST && cnt <= RD_LAST) begin
                    rd_valid = owner_oh;
                end
                if (cnt == RD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DONE: begin
                done = owner_oh;
                if (timed_out) begin
                    err = owner_oh;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
